// File: rtl/count_monitor_pkg.sv
// ---------------------------------------------------------------------------
// Module   : count_mon_pkg
// Brief    : Shared state encoding, defaults and successor helper for count_monitor
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package count_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int c_DEF_CNT_W    = 16;
    localparam int c_DEF_LOCK_LEN = 4;

    // 32-bit arithmetic leaves headroom above any WIDTH < 32, so x+1 never wraps.
    function automatic logic [31:0] succ(input logic [31:0] x, input logic [31:0] terminal);
        return (x == terminal) ? 32'd0 : x + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/count_monitor_if.sv
// ---------------------------------------------------------------------------
// Module   : count_monitor_if
// Brief    : Sample bus and status outputs between a counter and its monitor.
//            err_sticky exists only when COUNT_MON_STICKY_EN is defined.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface count_monitor_if
    import count_mon_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = c_DEF_CNT_W
);
    logic             valid;
    logic [WIDTH-1:0] number;
    logic             locked;
    logic [WIDTH-1:0] expected;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] wrap_count;
`ifdef COUNT_MON_STICKY_EN
    logic             err_sticky;

    modport master (output valid, number,
                    input  locked, expected, err_pulse, err_count, wrap_count, err_sticky);
    modport slave  (input  valid, number,
                    output locked, expected, err_pulse, err_count, wrap_count, err_sticky);
`else
    modport master (output valid, number,
                    input  locked, expected, err_pulse, err_count, wrap_count);
    modport slave  (input  valid, number,
                    output locked, expected, err_pulse, err_count, wrap_count);
`endif

endinterface

`default_nettype wire

// File: rtl/count_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// Module   : sat_counter
// Brief    : Saturating up-counter with increment enable and synchronous clear.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_clr) begin
            w_count_d = '0;
        end else if (i_inc && (r_count_q != '1)) begin
            w_count_d = r_count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        r_count_q <= w_count_d;
    end

    assign o_count = r_count_q;

endmodule

`default_nettype wire

// File: rtl/count_monitor.sv
// ---------------------------------------------------------------------------
// Module   : count_monitor
// Brief    : Locks onto a 0..TERMINAL wrapping count and flags skipped, repeated
//            or out-of-range samples. Optional COUNT_MON_STICKY_EN adds err_sticky.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module count_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 23,
    parameter int LOCK_LEN = c_DEF_LOCK_LEN,
    parameter int CNT_W    = c_DEF_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    count_monitor_if.slave mon
);

    localparam logic [WIDTH-1:0] c_TERMINAL = WIDTH'(TERMINAL);
    localparam logic [3:0]       c_LOCK_LEN = 4'(LOCK_LEN);

    state_t           r_state_q,     w_state_d;
    logic [WIDTH-1:0] r_expected_q,  w_expected_d;
    logic [3:0]       r_run_q,       w_run_d;
    logic             r_locked_q,    w_locked_d;
    logic             r_err_pulse_q, w_err_pulse_d;
    logic             w_wrap_inc;
    logic             w_in_range;
    logic             w_match;
    logic [WIDTH-1:0] w_succ;
    logic [3:0]       w_run_inc;

    assign w_in_range = (mon.number <= c_TERMINAL);
    assign w_match    = (mon.number == r_expected_q);
    assign w_succ     = WIDTH'(succ(32'(mon.number), 32'(TERMINAL)));
    assign w_run_inc  = r_run_q + 4'd1;

    always_comb begin
        w_state_d     = r_state_q;
        w_expected_d  = r_expected_q;
        w_run_d       = r_run_q;
        w_locked_d    = r_locked_q;
        w_err_pulse_d = 1'b0;
        w_wrap_inc    = 1'b0;
        if (mon.valid) begin
            case (r_state_q)
                ST_IDLE: begin
                    if (w_in_range) begin
                        w_state_d    = ST_SYNC;
                        w_expected_d = w_succ;
                        w_run_d      = 4'd0;
                    end
                end
                ST_SYNC: begin
                    if (!w_in_range) begin
                        w_state_d = ST_IDLE;
                        w_run_d   = 4'd0;
                    end else if (w_match) begin
                        w_expected_d = w_succ;
                        w_run_d      = w_run_inc;
                        if (w_run_inc == c_LOCK_LEN) begin
                            w_state_d  = ST_LOCKED;
                            w_locked_d = 1'b1;
                            w_run_d    = 4'd0;
                        end
                    end else begin
                        w_expected_d = w_succ;
                        w_run_d      = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (w_in_range && w_match) begin
                        w_expected_d = w_succ;
                        // A matching 0 can only follow TERMINAL, so it marks a wrap.
                        w_wrap_inc   = (mon.number == '0);
                    end else begin
                        w_err_pulse_d = 1'b1;
                        w_locked_d    = 1'b0;
                        w_run_d       = 4'd0;
                        if (w_in_range) begin
                            w_state_d    = ST_SYNC;
                            w_expected_d = w_succ;
                        end else begin
                            w_state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_d  = ST_IDLE;
                    w_locked_d = 1'b0;
                    w_run_d    = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_expected_q  <= '0;
            r_run_q       <= 4'd0;
            r_locked_q    <= 1'b0;
            r_err_pulse_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_expected_q  <= w_expected_d;
            r_run_q       <= w_run_d;
            r_locked_q    <= w_locked_d;
            r_err_pulse_q <= w_err_pulse_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk     (clk),
        .i_clr   (rst),
        .i_inc   (w_err_pulse_d),
        .o_count (mon.err_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_wrap_cnt (
        .clk     (clk),
        .i_clr   (rst),
        .i_inc   (w_wrap_inc),
        .o_count (mon.wrap_count)
    );

`ifdef COUNT_MON_STICKY_EN
    logic r_sticky_q;
    logic w_sticky_d;

    assign w_sticky_d = r_sticky_q | w_err_pulse_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky_q <= 1'b0;
        end else begin
            r_sticky_q <= w_sticky_d;
        end
    end

    assign mon.err_sticky = r_sticky_q;
`endif

    assign mon.locked    = r_locked_q;
    assign mon.expected  = r_expected_q;
    assign mon.err_pulse = r_err_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_count_monitor.sv
// ---------------------------------------------------------------------------
// Module   : tb_count_monitor
// Brief    : Directed self-checking bench for count_monitor (default build and
//            COUNT_MON_STICKY_EN); a small second instance exercises saturation.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_count_monitor;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    count_monitor_if #(.WIDTH(8), .CNT_W(16)) bus_a ();
    count_monitor_if #(.WIDTH(4), .CNT_W(3))  bus_b ();

    count_monitor #(.WIDTH(8), .TERMINAL(23), .LOCK_LEN(4), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .mon (bus_a)
    );

    count_monitor #(.WIDTH(4), .TERMINAL(3), .LOCK_LEN(1), .CNT_W(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .mon (bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic v, input int n);
        bus_a.valid  = v;
        bus_a.number = 8'(n);
        tick();
    endtask

    task automatic step_b(input logic v, input int n);
        bus_b.valid  = v;
        bus_b.number = 4'(n);
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        bus_a.valid  = 1'b0;
        bus_a.number = 8'd0;
        bus_b.valid  = 1'b0;
        bus_b.number = 4'd0;

        // Reset state
        tick();
        rst = 1'b0;
        chk("rst_locked", bus_a.locked, 0);
        chk("rst_expected", bus_a.expected, 0);
        chk("rst_pulse", bus_a.err_pulse, 0);
        chk("rst_err_count", bus_a.err_count, 0);
        chk("rst_wrap_count", bus_a.wrap_count, 0);
        chk("rst_b_err_count", bus_b.err_count, 0);
`ifdef COUNT_MON_STICKY_EN
        chk("rst_sticky", bus_a.err_sticky, 0);
`endif

        // Clean sequence 0..23,0..23
        for (int i = 0; i < 48; i++) begin
            step_a(1'b1, i % 24);
            chk("clean_locked", bus_a.locked, (i >= 4));
            chk("clean_expected", bus_a.expected, ((i % 24) == 23) ? 0 : (i % 24) + 1);
            chk("clean_pulse", bus_a.err_pulse, 0);
            if (i == 23) chk("clean_wrap_before", bus_a.wrap_count, 0);
            if (i == 24) chk("clean_wrap_after", bus_a.wrap_count, 1);
        end
        chk("clean_err_count", bus_a.err_count, 0);
        chk("clean_wrap_final", bus_a.wrap_count, 1);

        // Skip: locked 10,11,13 then relock on 14..17
        step_a(1'b1, 0);
        chk("skip_wrap2", bus_a.wrap_count, 2);
        for (int n = 1; n <= 11; n++) step_a(1'b1, n);
        chk("skip_pre_locked", bus_a.locked, 1);
        chk("skip_pre_expected", bus_a.expected, 12);
        step_a(1'b1, 13);
        chk("skip_pulse", bus_a.err_pulse, 1);
        chk("skip_err_count", bus_a.err_count, 1);
        chk("skip_locked", bus_a.locked, 0);
        chk("skip_expected", bus_a.expected, 14);
`ifdef COUNT_MON_STICKY_EN
        chk("skip_sticky", bus_a.err_sticky, 1);
`endif
        step_a(1'b1, 14);
        chk("skip_pulse_once", bus_a.err_pulse, 0);
        chk("skip_err_hold", bus_a.err_count, 1);
        step_a(1'b1, 15);
        step_a(1'b1, 16);
        chk("skip_not_yet_locked", bus_a.locked, 0);
        step_a(1'b1, 17);
        chk("skip_relocked", bus_a.locked, 1);
        chk("skip_relock_expected", bus_a.expected, 18);
`ifdef COUNT_MON_STICKY_EN
        chk("skip_sticky_relock", bus_a.err_sticky, 1);
`endif

        // Out-of-range 24 while locked, IDLE ignores 30, relock on 0..4
        for (int n = 18; n <= 23; n++) step_a(1'b1, n);
        chk("oor_pre_locked", bus_a.locked, 1);
        chk("oor_pre_expected", bus_a.expected, 0);
        step_a(1'b1, 24);
        chk("oor_pulse", bus_a.err_pulse, 1);
        chk("oor_err_count", bus_a.err_count, 2);
        chk("oor_locked", bus_a.locked, 0);
        step_a(1'b1, 30);
        chk("idle_pulse", bus_a.err_pulse, 0);
        chk("idle_err_count", bus_a.err_count, 2);
        for (int n = 0; n <= 3; n++) step_a(1'b1, n);
        chk("oor_not_yet_locked", bus_a.locked, 0);
        step_a(1'b1, 4);
        chk("oor_relocked", bus_a.locked, 1);
        chk("oor_relock_expected", bus_a.expected, 5);
        chk("oor_wrap_hold", bus_a.wrap_count, 2);

        // Valid gaps carrying garbage are ignored
        rst = 1'b1;
        step_a(1'b0, 0);
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step_a(1'b1, i);
            chk("gap_locked", bus_a.locked, (i >= 4));
            step_a(1'b0, 200);
            chk("gap_locked_hold", bus_a.locked, (i >= 4));
            chk("gap_expected_hold", bus_a.expected, (i == 23) ? 0 : i + 1);
            chk("gap_pulse", bus_a.err_pulse, 0);
        end
        step_a(1'b1, 0);
        chk("gap_wrap", bus_a.wrap_count, 1);
        chk("gap_err_count", bus_a.err_count, 0);
        chk("gap_locked_final", bus_a.locked, 1);

        // Three errors with relock, then reset with a mismatching valid sample
        step_a(1'b1, 5);
        for (int n = 6; n <= 9; n++) step_a(1'b1, n);
        step_a(1'b1, 20);
        for (int n = 21; n <= 23; n++) step_a(1'b1, n);
        step_a(1'b1, 0);
        chk("three_wrap_in_sync", bus_a.wrap_count, 1);
        step_a(1'b1, 3);
        for (int n = 4; n <= 7; n++) step_a(1'b1, n);
        chk("three_err_count", bus_a.err_count, 3);
        chk("three_locked", bus_a.locked, 1);
        chk("three_expected", bus_a.expected, 8);
        rst = 1'b1;
        step_a(1'b1, 15);
        rst = 1'b0;
        chk("rst2_locked", bus_a.locked, 0);
        chk("rst2_expected", bus_a.expected, 0);
        chk("rst2_pulse", bus_a.err_pulse, 0);
        chk("rst2_err_count", bus_a.err_count, 0);
        chk("rst2_wrap_count", bus_a.wrap_count, 0);
`ifdef COUNT_MON_STICKY_EN
        chk("rst2_sticky", bus_a.err_sticky, 0);
`endif
        step_a(1'b0, 0);

        // Saturation on a 3-bit error counter (TERMINAL=3, LOCK_LEN=1)
        step_b(1'b1, 0);
        step_b(1'b1, 1);
        chk("sat_locked", bus_b.locked, 1);
        chk("sat_expected", bus_b.expected, 2);
        for (int k = 1; k <= 10; k++) begin
            step_b(1'b1, 3);
            chk("sat_pulse", bus_b.err_pulse, 1);
            chk("sat_err_count", bus_b.err_count, (k < 7) ? k : 7);
            chk("sat_unlocked", bus_b.locked, 0);
            step_b(1'b1, 0);
            chk("sat_relocked", bus_b.locked, 1);
            step_b(1'b1, 1);
        end
        chk("sat_wrap_count", bus_b.wrap_count, 0);
        step_b(1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
